// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the opcode values that mark loads and stores, the funct3 width
// encodings, the MMIO register offsets, and two helpers that turn an
// access width and byte lane into a byte-enable mask or a misalignment flag.
package dmem_responder_pkg;

   localparam logic [6:0] LOAD  = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;

   typedef enum logic [1:0] {
      WIDTH_BYTE   = 2'b00,
      WIDTH_HALF   = 2'b01,
      WIDTH_WORD   = 2'b10,
      WIDTH_DOUBLE = 2'b11
   } width_e;

   // Offsets of the two 64-bit registers inside the 16-byte MMIO window.
   localparam logic [3:0] CYCLE_OFS = 4'd0;
   localparam logic [3:0] STORE_OFS = 4'd8;

   // Byte lanes touched by an access of the given width starting at lane.
   function automatic logic [7:0] byte_enable(width_e width, logic [2:0] lane);
      logic [7:0] base;
      case (width)
         WIDTH_BYTE:   base = 8'h01;
         WIDTH_HALF:   base = 8'h03;
         WIDTH_WORD:   base = 8'h0F;
         default:      base = 8'hFF;
      endcase
      return base << lane;
   endfunction

   // An access must start on a multiple of its own size.
   function automatic logic is_misaligned(width_e width, logic [2:0] lane);
      logic result;
      case (width)
         WIDTH_BYTE:   result = 1'b0;
         WIDTH_HALF:   result = lane[0];
         WIDTH_WORD:   result = |lane[1:0];
         default:      result = |lane;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/dmem_responder_lane_extract.sv
// dmem_lane_extract: combinational load-data formatter.
// Ports:
//   word   - 64-bit source word (RAM word or MMIO register)
//   lane   - starting byte lane, little-endian
//   funct3 - [1:0] access width, [2] 1 = zero-extend, 0 = sign-extend
//   result - right-aligned, extended load value
module dmem_lane_extract
   import dmem_responder_pkg::*;
(
   input  logic [63:0] word,
   input  logic [2:0]  lane,
   input  logic [2:0]  funct3,
   output logic [63:0] result
);

   logic [63:0] shifted;
   logic        unsigned_load;

   assign shifted       = word >> {lane, 3'b000};
   assign unsigned_load = funct3[2];

   // Keep the low bytes of the lane-aligned word and fill the rest with
   // either zeros or copies of the top kept bit.
   always_comb begin
      result = '0;
      case (width_e'(funct3[1:0]))
         WIDTH_BYTE:
            result = unsigned_load ? {56'b0, shifted[7:0]}
                                   : {{56{shifted[7]}}, shifted[7:0]};
         WIDTH_HALF:
            result = unsigned_load ? {48'b0, shifted[15:0]}
                                   : {{48{shifted[15]}}, shifted[15:0]};
         WIDTH_WORD:
            result = unsigned_load ? {32'b0, shifted[31:0]}
                                   : {{32{shifted[31]}}, shifted[31:0]};
         default:
            result = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-cycle data memory for the MEM stage.
// A DEPTH_WORDS x 64-bit RAM answers loads combinationally and commits
// byte-enable-merged stores on the rising clock edge. A 16-byte MMIO window
// at MMIO_BASE exposes a free-running cycle counter and a count of committed
// RAM stores. Misaligned or out-of-range accesses are dropped and latch a
// sticky fault together with the address of the first offender.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   addr_in             - byte address of the access
//   wdata_in            - right-aligned store data
//   mem_write           - store strobe
//   mem_inst            - MEM-stage instruction (opcode, funct3)
//   rdata_out           - extended load result, zero when no load
//   fault, fault_addr   - sticky fault flag and first faulting address
//   debug_addr          - byte address for the debug read port
//   debug_data          - RAM word selected by debug_addr
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 512,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr_in,
   input  logic [63:0] wdata_in,
   input  logic        mem_write,
   input  logic [31:0] mem_inst,
   output logic [63:0] rdata_out,
   output logic        fault,
   output logic [31:0] fault_addr,
   input  logic [31:0] debug_addr,
   output logic [63:0] debug_data
);

   localparam int ADDR_W = $clog2(DEPTH_WORDS);

   logic [63:0]       mem [DEPTH_WORDS];

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   width_e            width;
   logic [2:0]        lane;
   logic [ADDR_W-1:0] word_idx;
   logic              is_load;
   logic              is_store;
   logic              in_ram;
   logic              in_mmio;
   logic [31:0]       mmio_off;
   logic              bad_access;
   logic              ram_commit;
   logic [63:0]       mmio_word;
   logic [63:0]       load_word;
   logic [63:0]       extracted;
   logic [7:0]        wr_enable;
   logic [63:0]       wr_shifted;
   logic [63:0]       cycle_cnt;
   logic [63:0]       store_cnt;
   logic              unused_bits;

   assign opcode   = mem_inst[6:0];
   assign funct3   = mem_inst[14:12];
   assign width    = width_e'(funct3[1:0]);
   assign lane     = addr_in[2:0];
   assign word_idx = addr_in[ADDR_W+2:3];

   assign is_load  = (opcode == LOAD);
   assign is_store = (opcode == STORE) && mem_write;

   // RAM occupies [0, DEPTH_WORDS*8); the MMIO test uses a subtraction so the
   // window may sit anywhere, including right at the top of the address map.
   assign in_ram   = (addr_in[31:ADDR_W+3] == '0);
   assign mmio_off = addr_in - MMIO_BASE;
   assign in_mmio  = (mmio_off[31:4] == '0);

   assign bad_access = (is_load || is_store) &&
                       (is_misaligned(width, lane) || !(in_ram || in_mmio));

   // MMIO stores are accepted but have no effect, so only RAM stores commit.
   assign ram_commit = is_store && in_ram && !bad_access;

   // Pick the MMIO register; the lane bits then select bytes within it.
   always_comb begin
      mmio_word = '0;
      case (mmio_off[3:0] & 4'h8)
         CYCLE_OFS: mmio_word = cycle_cnt;
         STORE_OFS: mmio_word = store_cnt;
         default:   mmio_word = '0;
      endcase
   end

   assign load_word = in_ram ? mem[word_idx] : mmio_word;

   dmem_lane_extract u_extract (
      .word   (load_word),
      .lane   (lane),
      .funct3 (funct3),
      .result (extracted)
   );

   assign rdata_out  = (is_load && !bad_access) ? extracted : '0;
   assign debug_data = mem[debug_addr[ADDR_W+2:3]];

   assign wr_enable  = byte_enable(width, lane);
   assign wr_shifted = wdata_in << {lane, 3'b000};

   // RAM write port. The array is never cleared, but a store that meets an
   // edge while reset is high must not land, hence reset in the sensitivity
   // list guarding the write.
   always_ff @(posedge clk or posedge rst) begin
      if (!rst) begin
         if (ram_commit) begin
            for (int b = 0; b < 8; b++) begin
               if (wr_enable[b]) begin
                  mem[word_idx][8*b +: 8] <= wr_shifted[8*b +: 8];
               end
            end
         end
      end
   end

   // Free-running cycle counter and committed-store counter; both wrap
   // naturally at 2^64.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
         store_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (ram_commit) begin
            store_cnt <= store_cnt + 64'd1;
         end
      end
   end

   // Sticky fault: only the first bad access after reset records its address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault      <= 1'b0;
         fault_addr <= '0;
      end else if (bad_access) begin
         fault <= 1'b1;
         if (!fault) begin
            fault_addr <= addr_in;
         end
      end
   end

   assign unused_bits = ^{mem_inst[31:15], mem_inst[11:7],
                          debug_addr[31:ADDR_W+3], debug_addr[2:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Stimulus drives one operation per
// cycle and pushes the expected outputs, computed from a byte-addressed
// reference memory and plain counters, onto a scoreboard queue; a monitor
// pops and compares on every falling clock edge.
module tb_dmem_responder;

   localparam int          DEPTH = 512;
   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam logic [6:0]  OP_LD = 7'b0000011;
   localparam logic [6:0]  OP_ST = 7'b0100011;
   localparam logic [6:0]  OP_AL = 7'b0110011;

   logic        clk;
   logic        rst;
   logic [31:0] addr_in;
   logic [63:0] wdata_in;
   logic        mem_write;
   logic [31:0] mem_inst;
   logic [63:0] rdata_out;
   logic        fault;
   logic [31:0] fault_addr;
   logic [31:0] debug_addr;
   logic [63:0] debug_data;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr_in    (addr_in),
      .wdata_in   (wdata_in),
      .mem_write  (mem_write),
      .mem_inst   (mem_inst),
      .rdata_out  (rdata_out),
      .fault      (fault),
      .fault_addr (fault_addr),
      .debug_addr (debug_addr),
      .debug_data (debug_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      bit          chk_rd;
      logic [63:0] rd;
      logic        flt;
      logic [31:0] fa;
      bit          chk_dbg;
      logic [63:0] dbg;
   } exp_t;

   exp_t            sb_q[$];
   int              checks = 0;
   int              failures = 0;
   int              op_count = 0;

   // Reference state: memory as individual bytes, counters as numbers.
   logic [7:0]      ref_mem [int unsigned];
   longint unsigned ref_cycles = 0;
   longint unsigned ref_stores = 0;
   bit              ref_fault = 0;
   logic [31:0]     ref_faddr = '0;

   function automatic bit model_in_ram(logic [31:0] a);
      return {32'b0, a} < 64'(DEPTH) * 64'd8;
   endfunction

   function automatic bit model_in_mmio(logic [31:0] a);
      logic [63:0] x = {32'b0, a};
      logic [63:0] b = {32'b0, BASE};
      return (x >= b) && (x < b + 64'd16);
   endfunction

   function automatic logic [7:0] model_byte(logic [31:0] a);
      longint unsigned off;
      longint unsigned regv;
      if (model_in_ram(a)) return ref_mem[a];
      off  = longint'(a - BASE);
      regv = (off < 8) ? ref_cycles : ref_stores;
      return 8'(regv >> (8 * (off % 8)));
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Monitor: compares whatever the DUT presents mid-cycle with the
   // oldest expectation.
   exp_t mon_e;
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         if (mon_e.chk_rd) checkOutput({mon_e.tag, " rdata"}, rdata_out, mon_e.rd);
         checkOutput({mon_e.tag, " fault"}, {63'b0, fault}, {63'b0, mon_e.flt});
         checkOutput({mon_e.tag, " fault_addr"}, {32'b0, fault_addr}, {32'b0, mon_e.fa});
         if (mon_e.chk_dbg) checkOutput({mon_e.tag, " debug"}, debug_data, mon_e.dbg);
      end
   end

   // Random debug address within the initialised region, with junk in the
   // bits above the RAM range and in the byte offset.
   task automatic pickDebug(output logic [31:0] dbg, output bit ok, output logic [63:0] word);
      logic [31:0] wbase;
      dbg   = ($urandom & ~32'(DEPTH * 8 - 1)) | (32'($urandom_range(0, 31)) << 3)
              | 32'($urandom_range(0, 7));
      wbase = ((dbg >> 3) % DEPTH) * 8;
      ok    = 1;
      word  = '0;
      for (int i = 0; i < 8; i++) begin
         if (!ref_mem.exists(wbase + i)) ok = 0;
         else word |= 64'(ref_mem[wbase + i]) << (8 * i);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] opc, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [63:0] data);
      exp_t        e;
      logic [31:0] inst;
      logic [31:0] dbg;
      int          n;
      bit          is_ld, is_st, bad, ram;
      logic [63:0] val;
      inst        = $urandom;
      inst[6:0]   = opc;
      inst[14:12] = f3;
      pickDebug(dbg, e.chk_dbg, e.dbg);
      mem_inst   = inst;
      mem_write  = we;
      addr_in    = addr;
      wdata_in   = data;
      debug_addr = dbg;

      is_ld = (opc == OP_LD);
      is_st = (opc == OP_ST) && we;
      n     = 1 << f3[1:0];
      ram   = model_in_ram(addr);
      bad   = (is_ld || is_st) &&
              ((addr % n) != 0 || !(ram || model_in_mmio(addr)));

      e.tag    = $sformatf("op%0d@%h", op_count, addr);
      op_count++;
      e.chk_rd = 1;
      val      = '0;
      if (is_ld && !bad) begin
         for (int i = 0; i < n; i++) begin
            if (ram && !ref_mem.exists(addr + i)) e.chk_rd = 0;
            else val |= 64'(model_byte(addr + i)) << (8 * i);
         end
         if (!f3[2] && n < 8 && val[8*n-1]) val |= ~((64'd1 << (8 * n)) - 64'd1);
      end
      e.rd  = val;
      e.flt = ref_fault;
      e.fa  = ref_faddr;
      sb_q.push_back(e);

      // Effects that become visible after the coming edge.
      if (bad) begin
         if (!ref_fault) ref_faddr = addr;
         ref_fault = 1;
      end else if (is_st && ram) begin
         for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'(data >> (8 * i));
         ref_stores++;
      end
      ref_cycles++;
      @(posedge clk);
      #1;
   endtask

   // Holds reset across one edge while a store (or idle) is presented.
   task automatic applyReset(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [63:0] data);
      exp_t        e;
      logic [31:0] dbg;
      pickDebug(dbg, e.chk_dbg, e.dbg);
      mem_inst   = {17'b0, f3, 5'd0, OP_ST};
      mem_write  = we;
      addr_in    = addr;
      wdata_in   = data;
      debug_addr = dbg;
      rst        = 1'b1;
      ref_cycles = 0;
      ref_stores = 0;
      ref_fault  = 0;
      ref_faddr  = '0;
      e.tag    = $sformatf("rst%0d", op_count);
      op_count++;
      e.chk_rd = 1;
      e.rd     = '0;
      e.flt    = 1'b0;
      e.fa     = '0;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [6:0]  opc;
      logic [31:0] a;
      int          kind;
      rst        = 1'b1;
      addr_in    = '0;
      wdata_in   = '0;
      mem_write  = 1'b0;
      mem_inst   = '0;
      debug_addr = '0;
      @(posedge clk);
      #1;
      applyReset(1'b0, 3'b011, 32'h0, 64'h0);

      // Give the first 32 words known contents.
      for (int w = 0; w < 32; w++) applyStimulus(OP_ST, 1, 3'b011, 32'(w * 8), {$urandom, $urandom});

      // Store then narrow loads.
      applyStimulus(OP_ST, 1, 3'b011, 32'h10, 64'h1122334455667788);
      applyStimulus(OP_LD, 0, 3'b000, 32'h17, 64'h0);
      applyStimulus(OP_LD, 0, 3'b001, 32'h10, 64'h0);
      applyStimulus(OP_LD, 0, 3'b010, 32'h14, 64'h0);
      // Sign and zero extension.
      applyStimulus(OP_ST, 1, 3'b000, 32'h20, 64'h80);
      applyStimulus(OP_LD, 0, 3'b000, 32'h20, 64'h0);
      applyStimulus(OP_LD, 0, 3'b100, 32'h20, 64'h0);
      applyStimulus(OP_ST, 1, 3'b001, 32'h22, 64'h8001);
      applyStimulus(OP_LD, 0, 3'b101, 32'h22, 64'h0);
      applyStimulus(OP_LD, 0, 3'b001, 32'h22, 64'h0);
      // Byte merge.
      applyStimulus(OP_ST, 1, 3'b011, 32'h30, 64'h0);
      applyStimulus(OP_ST, 1, 3'b000, 32'h33, 64'hAB);
      applyStimulus(OP_LD, 0, 3'b011, 32'h30, 64'h0);
      // Misaligned store, then a second misaligned access.
      applyStimulus(OP_ST, 1, 3'b010, 32'h42, 64'hDEADBEEF);
      applyStimulus(OP_LD, 0, 3'b011, 32'h40, 64'h0);
      applyStimulus(OP_LD, 0, 3'b011, 32'h45, 64'h0);
      applyStimulus(OP_AL, 0, 3'b000, 32'h0, 64'h0);

      // Reset while a store is presented, then cycle and store counters.
      applyReset(1'b1, 3'b011, 32'h50, 64'hCAFEF00DCAFEF00D);
      applyStimulus(OP_AL, 0, 3'b000, 32'h0, 64'h0);
      applyStimulus(OP_AL, 0, 3'b000, 32'h0, 64'h0);
      applyStimulus(OP_AL, 0, 3'b000, 32'h0, 64'h0);
      applyStimulus(OP_LD, 0, 3'b011, BASE, 64'h0);
      applyStimulus(OP_LD, 0, 3'b011, 32'h50, 64'h0);
      applyStimulus(OP_ST, 1, 3'b011, 32'h58, 64'h1);
      applyStimulus(OP_ST, 1, 3'b000, 32'h60, 64'h2);
      applyStimulus(OP_ST, 1, 3'b011, BASE + 8, 64'h3);
      applyStimulus(OP_LD, 0, 3'b011, BASE + 8, 64'h0);
      applyStimulus(OP_LD, 0, 3'b110, BASE + 4, 64'h0);
      applyStimulus(OP_AL, 0, 3'b000, 32'h0, 64'h0);

      // Out-of-range accesses just past RAM and around the MMIO window.
      applyStimulus(OP_LD, 0, 3'b011, 32'(DEPTH * 8), 64'h0);
      applyStimulus(OP_LD, 0, 3'b011, BASE + 16, 64'h0);
      applyStimulus(OP_LD, 0, 3'b011, BASE - 8, 64'h0);
      applyStimulus(OP_AL, 0, 3'b000, 32'h0, 64'h0);

      // Randomised traffic with occasional resets.
      for (int t = 0; t < 400; t++) begin
         kind = $urandom_range(0, 39);
         opc  = ($urandom_range(0, 1) == 0) ? OP_LD : OP_ST;
         if (kind < 14) begin
            applyStimulus(OP_LD, 0, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), 64'h0);
         end else if (kind < 26) begin
            applyStimulus(OP_ST, 1, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
                          {$urandom, $urandom});
         end else if (kind < 31) begin
            applyStimulus(opc, 1, 3'($urandom_range(0, 7)), BASE + 32'($urandom_range(0, 15)),
                          {$urandom, $urandom});
         end else if (kind < 34) begin
            case ($urandom_range(0, 2))
               0:       a = 32'(DEPTH * 8) + 32'($urandom_range(0, 4095));
               1:       a = BASE + 32'd16 + 32'($urandom_range(0, 255));
               default: a = BASE - 32'd1 - 32'($urandom_range(0, 255));
            endcase
            applyStimulus(opc, 1, 3'($urandom_range(0, 7)), a, {$urandom, $urandom});
         end else if (kind < 39) begin
            applyStimulus(($urandom_range(0, 1) == 0) ? OP_AL : OP_ST, 0,
                          3'($urandom_range(0, 7)), $urandom, {$urandom, $urandom});
         end else begin
            applyReset(1'b1, 3'($urandom_range(0, 3)), 32'($urandom_range(0, 31) * 8),
                       {$urandom, $urandom});
         end
      end

      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
